// File: rtl/uart_rx_ctrl_if.sv
// Receive-side UART bus: line/tick inputs toward the framing controller and
// the received word plus status flags back to the consumer.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 baud_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 checkstp;
  logic                 stp_in;
  logic                 busy;

  modport master (
    output baud_tick, rx,
    input  rx_data, rx_valid, parity_err, frame_err, checkstp, stp_in, busy
  );

  modport slave (
    input  baud_tick, rx,
    output rx_data, rx_valid, parity_err, frame_err, checkstp, stp_in, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive bit-timing/framing controller: start-bit validation, LSB-first
// data shift, optional parity check and stop-bit strobe on an oversampled line.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, nxt;
  logic [CNT_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_mis;
  logic                 mid_pt, end_pt, busy_c;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, parity_err_q, frame_err_q, checkstp_q, stp_in_q;

  // Parity bit the transmitter should have sent for a given data word.
  function automatic logic exp_par(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.baud_tick && !bus.rx) nxt = START;
      START:   if (mid_pt) nxt = bus.rx ? IDLE : DATA;
      DATA:    if (end_pt && bit_idx == LAST_IDX) nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (end_pt) nxt = STOP;
      STOP:    if (end_pt) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Sample points: mid start bit after half a period, every later bit one full period on.
  always_comb begin
    busy_c = (state != IDLE);
    mid_pt = bus.baud_tick && (state == START) && (tick_cnt == HALF_CNT);
    end_pt = bus.baud_tick && (state == DATA || state == PARITY || state == STOP)
             && (tick_cnt == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_idx  <= '0;
    end else if (bus.baud_tick) begin
      if (state == IDLE || mid_pt || end_pt) tick_cnt <= '0;
      else                                   tick_cnt <= tick_cnt + CNT_W'(1);
      if (mid_pt)
        bit_idx <= '0;
      else if (end_pt && state == DATA && bit_idx != LAST_IDX)
        bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  // Shift register and parity flag carry no reset: a new frame always reinitialises them.
  always_ff @(posedge clk) begin
    if (mid_pt) par_mis <= 1'b0;
    else if (end_pt && state == PARITY) par_mis <= bus.rx ^ exp_par(shreg);
    if (end_pt && state == DATA) shreg <= {bus.rx, shreg[DATA_BITS-1:1]};
  end

  // Frame completion: one-cycle strobes, word and flags held until the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      checkstp_q   <= 1'b0;
      stp_in_q     <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      checkstp_q <= 1'b0;
      if (end_pt && state == STOP) begin
        rx_valid_q   <= 1'b1;
        checkstp_q   <= 1'b1;
        stp_in_q     <= bus.rx;
        frame_err_q  <= ~bus.rx;
        rx_data_q    <= shreg;
        parity_err_q <= (PARITY_EN != 0) && par_mis;
      end
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.checkstp   = checkstp_q;
  assign bus.stp_in     = stp_in_q;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: three instances (even parity, odd parity, no parity)
// on a shared clock and baud tick, driven by directed frames.
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud = 1'b0;
  logic rx_l [3];

  always #5 clk = ~clk;

  // baud_tick: one clk high in every four
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 baud = 1'b1;
      @(posedge clk);
      #1 baud = 1'b0;
    end
  end

  uart_rx_ctrl_if #(.DATA_BITS(8)) if_e ();
  uart_rx_ctrl_if #(.DATA_BITS(8)) if_o ();
  uart_rx_ctrl_if #(.DATA_BITS(8)) if_n ();

  assign if_e.baud_tick = baud;
  assign if_o.baud_tick = baud;
  assign if_n.baud_tick = baud;
  assign if_e.rx = rx_l[0];
  assign if_o.rx = rx_l[1];
  assign if_n.rx = rx_l[2];

  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0))
    dut_e (.clk(clk), .rst(rst), .bus(if_e.slave));
  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1))
    dut_o (.clk(clk), .rst(rst), .bus(if_o.slave));
  uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0))
    dut_n (.clk(clk), .rst(rst), .bus(if_n.slave));

  logic [2:0] v_w, c_w, s_w, pe_w, fe_w, b_w;
  logic [7:0] d_w [3];
  assign v_w  = {if_n.rx_valid,   if_o.rx_valid,   if_e.rx_valid};
  assign c_w  = {if_n.checkstp,   if_o.checkstp,   if_e.checkstp};
  assign s_w  = {if_n.stp_in,     if_o.stp_in,     if_e.stp_in};
  assign pe_w = {if_n.parity_err, if_o.parity_err, if_e.parity_err};
  assign fe_w = {if_n.frame_err,  if_o.frame_err,  if_e.frame_err};
  assign b_w  = {if_n.busy,       if_o.busy,       if_e.busy};
  assign d_w[0] = if_e.rx_data;
  assign d_w[1] = if_o.rx_data;
  assign d_w[2] = if_n.rx_data;

  int         nvalid [3] = '{0, 0, 0};
  int         nchk   [3] = '{0, 0, 0};
  logic       lstp   [3];
  logic [7:0] log_d  [3][16];
  logic [1:0] log_e  [3][16];

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (v_w[i]) begin
        nvalid[i] <= nvalid[i] + 1;
        log_d[i][nvalid[i] % 16] <= d_w[i];
        log_e[i][nvalid[i] % 16] <= {pe_w[i], fe_w[i]};
      end
      if (c_w[i]) begin
        nchk[i] <= nchk[i] + 1;
        lstp[i] <= s_w[i];
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud !== 1'b1) @(posedge clk);
    end
    #2;
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input logic p,
                            input logic s, input bit has_par);
    rx_l[i] = 1'b0;
    ticks(16);
    for (int k = 0; k < 8; k++) begin
      rx_l[i] = d[k];
      ticks(16);
    end
    if (has_par) begin
      rx_l[i] = p;
      ticks(16);
    end
    rx_l[i] = s;
    ticks(16);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, c0;
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[2] = '{0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[6] = '{2, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) rx_l[i] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    chk("reset busy",       32'(if_e.busy),       32'd0);
    chk("reset rx_valid",   32'(if_e.rx_valid),   32'd0);
    chk("reset rx_data",    32'(if_e.rx_data),    32'd0);
    chk("reset parity_err", 32'(if_e.parity_err), 32'd0);
    chk("reset frame_err",  32'(if_e.frame_err),  32'd0);
    chk("reset checkstp",   32'(if_e.checkstp),   32'd0);
    chk("reset stp_in",     32'(if_e.stp_in),     32'd1);
    ticks(2);

    for (int v = 0; v < 7; v++) begin
      int i;
      i  = vecs[v].inst;
      n0 = nvalid[i];
      c0 = nchk[i];
      send_frame(i, vecs[v].data, vecs[v].par, vecs[v].stop, i != 2);
      rx_l[i] = 1'b1;
      ticks(24);
      chk($sformatf("v%0d valid count", v), 32'(nvalid[i] - n0), 32'd1);
      chk($sformatf("v%0d checkstp count", v), 32'(nchk[i] - c0), 32'd1);
      chk($sformatf("v%0d rx_data", v), 32'(log_d[i][n0 % 16]), 32'(vecs[v].exp_data));
      chk($sformatf("v%0d parity_err", v), 32'(log_e[i][n0 % 16][1]), 32'(vecs[v].exp_pe));
      chk($sformatf("v%0d frame_err", v), 32'(log_e[i][n0 % 16][0]), 32'(vecs[v].exp_fe));
      chk($sformatf("v%0d stp_in at strobe", v), 32'(lstp[i]), 32'(vecs[v].stop));
      chk($sformatf("v%0d stp_in held", v), 32'(s_w[i]), 32'(vecs[v].stop));
      chk($sformatf("v%0d frame_err held", v), 32'(fe_w[i]), 32'(vecs[v].exp_fe));
      chk($sformatf("v%0d busy idle", v), 32'(b_w[i]), 32'd0);
    end

    // Glitch: three low ticks is a false start
    n0 = nvalid[0];
    c0 = nchk[0];
    rx_l[0] = 1'b0;
    ticks(3);
    chk("glitch busy during", 32'(if_e.busy), 32'd1);
    rx_l[0] = 1'b1;
    ticks(6);
    chk("glitch busy after", 32'(if_e.busy), 32'd0);
    ticks(20);
    chk("glitch no rx_valid", 32'(nvalid[0] - n0), 32'd0);
    chk("glitch no checkstp", 32'(nchk[0] - c0), 32'd0);

    // Reset during data bit 4 of 0xFF
    n0 = nvalid[0];
    c0 = nchk[0];
    rx_l[0] = 1'b0;
    ticks(16);
    rx_l[0] = 1'b1;
    ticks(16 * 4 + 8);
    chk("pre-reset busy", 32'(if_e.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    chk("mid reset busy", 32'(if_e.busy), 32'd0);
    chk("mid reset rx_data", 32'(if_e.rx_data), 32'd0);
    chk("mid reset stp_in", 32'(if_e.stp_in), 32'd1);
    chk("mid reset parity_err", 32'(if_e.parity_err), 32'd0);
    ticks(16 * 8);
    chk("mid reset no rx_valid", 32'(nvalid[0] - n0), 32'd0);
    chk("mid reset no checkstp", 32'(nchk[0] - c0), 32'd0);
    n0 = nvalid[0];
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    ticks(24);
    chk("after reset valid count", 32'(nvalid[0] - n0), 32'd1);
    chk("after reset rx_data", 32'(log_d[0][n0 % 16]), 32'h5A);
    chk("after reset flags", 32'(log_e[0][n0 % 16]), 32'd0);

    // Back-to-back frames without parity and no idle gap
    n0 = nvalid[2];
    c0 = nchk[2];
    send_frame(2, 8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(2, 8'hAA, 1'b0, 1'b1, 1'b0);
    ticks(24);
    chk("b2b valid count", 32'(nvalid[2] - n0), 32'd2);
    chk("b2b checkstp count", 32'(nchk[2] - c0), 32'd2);
    chk("b2b first data", 32'(log_d[2][n0 % 16]), 32'h55);
    chk("b2b first flags", 32'(log_e[2][n0 % 16]), 32'd0);
    chk("b2b second data", 32'(log_d[2][(n0 + 1) % 16]), 32'hAA);
    chk("b2b second flags", 32'(log_e[2][(n0 + 1) % 16]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
